// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the core scheduler and one ALU lane.
// The scheduler drives the master side and the ALU is the slave.
interface alu_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output enable, start, op, rs, rt,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  enable, start, op, rs, rt,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// Per-thread ALU: ADD/SUB/MUL/CMP complete in one cycle, DIV/MOD run on an
// iterative restoring divider behind a start/busy/done handshake.
module alu_multicycle #(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic clk,
  input  logic reset,
  alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;
  localparam logic [2:0] OP_MOD = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    DIV_RUN,
    DIV_DONE
  } state_t;

  state_t           state_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             dbz_reg;
  logic             is_mod_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [CW-1:0]    count_reg;

  logic             accept;
  logic             is_div_op;
  logic             lt;
  logic             gt;
  logic [WIDTH-1:0] single_result;
  logic [WIDTH:0]   shifted;
  logic             take;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign accept    = bus.start & bus.enable & ~busy_reg;
  assign is_div_op = (bus.op == OP_DIV) || (bus.op == OP_MOD);

  // Single-cycle datapath; CMP uses a real magnitude compare so wrapped
  // differences never flip the answer.
  always_comb begin
    lt            = 1'b0;
    gt            = 1'b0;
    single_result = '0;
    if (SIGNED_CMP) begin
      lt = $signed(bus.rs) < $signed(bus.rt);
      gt = $signed(bus.rs) > $signed(bus.rt);
    end else begin
      lt = bus.rs < bus.rt;
      gt = bus.rs > bus.rt;
    end
    case (bus.op)
      OP_ADD:  single_result = bus.rs + bus.rt;
      OP_SUB:  single_result = bus.rs - bus.rt;
      OP_MUL:  single_result = bus.rs * bus.rt;
      OP_CMP:  single_result[2:0] = {gt, ~gt & ~lt, lt};
      default: single_result = '0;
    endcase
  end

  // One restoring step: dividend bits shift out of quo_reg's MSB while
  // quotient bits shift in at its LSB.
  always_comb begin
    shifted  = {rem_reg, quo_reg[WIDTH-1]};
    take     = shifted >= {1'b0, dvs_reg};
    rem_next = take ? WIDTH'(shifted - {1'b0, dvs_reg}) : shifted[WIDTH-1:0];
    quo_next = {quo_reg[WIDTH-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
      is_mod_reg <= 1'b0;
      result_reg <= '0;
      quo_reg    <= '0;
      rem_reg    <= '0;
      dvs_reg    <= '0;
      count_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        DIV_RUN: begin
          if (bus.enable) begin
            quo_reg   <= quo_next;
            rem_reg   <= rem_next;
            count_reg <= count_reg - CW'(1);
            if (count_reg == CW'(1)) begin
              result_reg <= is_mod_reg ? rem_next : quo_next;
              done_reg   <= 1'b1;
              busy_reg   <= 1'b0;
              state_reg  <= DIV_DONE;
            end
          end
        end
        default: begin
          // IDLE and DIV_DONE both accept, giving back-to-back issue.
          state_reg <= IDLE;
          if (accept) begin
            dbz_reg <= 1'b0;
            if (is_div_op && (bus.rt == '0)) begin
              result_reg <= (bus.op == OP_DIV) ? '1 : bus.rs;
              dbz_reg    <= 1'b1;
              done_reg   <= 1'b1;
            end else if (is_div_op) begin
              state_reg  <= DIV_RUN;
              busy_reg   <= 1'b1;
              is_mod_reg <= (bus.op == OP_MOD);
              quo_reg    <= bus.rs;
              rem_reg    <= '0;
              dvs_reg    <= bus.rt;
              count_reg  <= CW'(WIDTH);
            end else begin
              result_reg <= single_result;
              done_reg   <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.result      = result_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed and randomized checks of alu_multicycle against an arithmetic
// reference model (plain /, %, * on wide integers).
module tb_alu_multicycle;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_if #(.WIDTH(8))  ia ();
  alu_if #(.WIDTH(8))  ib ();
  alu_if #(.WIDTH(16)) ic ();

  alu_multicycle #(.WIDTH(8),  .SIGNED_CMP(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  alu_multicycle #(.WIDTH(8),  .SIGNED_CMP(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ib));
  alu_multicycle #(.WIDTH(16), .SIGNED_CMP(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(ic));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint model_res(input int w, input bit sgn, input logic [2:0] op,
                                       input longint a, input longint b);
    longint mask;
    longint sa;
    longint sb;
    mask = (longint'(1) << w) - 1;
    sa = a;
    sb = b;
    case (op)
      3'd0: return (a + b) & mask;
      3'd1: return (a - b) & mask;
      3'd2: return (a * b) & mask;
      3'd3: return (b == 0) ? mask : a / b;
      3'd5: return (b == 0) ? a : a % b;
      3'd4: begin
        if (sgn) begin
          if (a >= (longint'(1) << (w - 1))) sa = a - (longint'(1) << w);
          if (b >= (longint'(1) << (w - 1))) sb = b - (longint'(1) << w);
        end
        return (sa > sb) ? 4 : ((sa == sb) ? 2 : 1);
      end
      default: return 0;
    endcase
  endfunction

  // Issue one op on lane A, wait for done, check latency/result/flags.
  task automatic run_a(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit stall, input string tag, output logic [7:0] r);
    longint er;
    bit     ediv;
    bit     edz;
    bit     seen;
    int     c;
    int     en_edges;
    er   = model_res(8, 1'b1, op, longint'(a), longint'(b));
    ediv = (op == 3'd3 || op == 3'd5) && (b != 8'd0);
    edz  = (op == 3'd3 || op == 3'd5) && (b == 8'd0);
    ia.op = op; ia.rs = a; ia.rt = b; ia.start = 1'b1; ia.enable = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b0;
    ia.op = 3'($urandom); ia.rs = 8'($urandom); ia.rt = 8'($urandom);
    c = 1; en_edges = 0; seen = 1'b0;
    while (!seen && c < 200) begin
      if (ia.done === 1'b1) seen = 1'b1;
      else begin
        if (ediv) chk({tag, "_busy"}, 64'(ia.busy), 64'd1);
        if (stall) ia.enable = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        if (ia.enable) en_edges++;
        #1; c++;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (stall) chk({tag, "_enabled_edges"}, 64'(en_edges), ediv ? 64'd8 : 64'd0);
    else       chk({tag, "_latency"}, 64'(c), ediv ? 64'd9 : 64'd1);
    chk({tag, "_result"}, 64'(ia.result), 64'(er));
    chk({tag, "_dbz"}, 64'(ia.div_by_zero), 64'(edz));
    chk({tag, "_busy_at_done"}, 64'(ia.busy), 64'd0);
    r = ia.result;
    $display("%s op=%0d rs=%0h rt=%0h result=%0h dbz=%0b cycles=%0d", tag, op, a, b, r, ia.div_by_zero, c);
    ia.enable = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(ia.done), 64'd0);
  endtask

  task automatic run_c(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input string tag);
    longint er;
    bit     ediv;
    int     c;
    er   = model_res(16, 1'b1, op, longint'(a), longint'(b));
    ediv = (op == 3'd3 || op == 3'd5) && (b != 16'd0);
    ic.op = op; ic.rs = a; ic.rt = b; ic.start = 1'b1; ic.enable = 1'b1;
    @(posedge clk); #1;
    ic.start = 1'b0;
    c = 1;
    while (ic.done !== 1'b1 && c < 200) begin
      @(posedge clk); #1; c++;
    end
    chk({tag, "_latency"}, 64'(c), ediv ? 64'd17 : 64'd1);
    chk({tag, "_result"}, 64'(ic.result), 64'(er));
    $display("%s op=%0d rs=%0h rt=%0h result=%0h cycles=%0d", tag, op, a, b, ic.result, c);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] r;
    int         c;
    int         pulses;
    bit         seen;
    reset = 1'b1;
    ia.enable = 1'b0; ia.start = 1'b0; ia.op = 3'd0; ia.rs = 8'd0; ia.rt = 8'd0;
    ib.enable = 1'b0; ib.start = 1'b0; ib.op = 3'd0; ib.rs = 8'd0; ib.rt = 8'd0;
    ic.enable = 1'b0; ic.start = 1'b0; ic.op = 3'd0; ic.rs = 16'd0; ic.rt = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   64'(ia.busy),        64'd0);
    chk("reset_done",   64'(ia.done),        64'd0);
    chk("reset_result", 64'(ia.result),      64'd0);
    chk("reset_dbz",    64'(ia.div_by_zero), 64'd0);
    reset = 1'b0;
    ia.enable = 1'b1; ib.enable = 1'b1; ic.enable = 1'b1;
    @(posedge clk); #1;

    run_a(3'd0, 8'd200, 8'd100, 1'b0, "add", r);  chk("add_const", 64'(r), 64'd44);
    run_a(3'd1, 8'd5,   8'd7,   1'b0, "sub", r);  chk("sub_const", 64'(r), 64'd254);
    run_a(3'd2, 8'd20,  8'd20,  1'b0, "mul", r);  chk("mul_const", 64'(r), 64'd144);
    run_a(3'd4, 8'hFF,  8'h01,  1'b0, "cmp_signed", r); chk("cmp_signed_const", 64'(r), 64'h01);
    run_a(3'd4, 8'h33,  8'h33,  1'b0, "cmp_eq", r);     chk("cmp_eq_const", 64'(r), 64'h02);
    run_a(3'd6, 8'h12,  8'h34,  1'b0, "reserved", r);   chk("reserved_const", 64'(r), 64'h00);

    ib.op = 3'd4; ib.rs = 8'hFF; ib.rt = 8'h01; ib.start = 1'b1;
    @(posedge clk); #1;
    ib.start = 1'b0;
    chk("cmp_unsigned_done",   64'(ib.done),   64'd1);
    chk("cmp_unsigned_result", 64'(ib.result), 64'h04);
    $display("cmp_unsigned rs=ff rt=01 result=%0h", ib.result);

    run_a(3'd3, 8'd200, 8'd7, 1'b0, "div", r);  chk("div_const", 64'(r), 64'd28);
    run_a(3'd5, 8'd200, 8'd7, 1'b0, "mod", r);  chk("mod_const", 64'(r), 64'd4);
    run_a(3'd3, 8'd50,  8'd0, 1'b0, "div0", r); chk("div0_const", 64'(r), 64'hFF);
    run_a(3'd5, 8'd50,  8'd0, 1'b0, "mod0", r); chk("mod0_const", 64'(r), 64'd50);
    run_a(3'd0, 8'd1,   8'd1, 1'b0, "add_clr", r); chk("add_clr_const", 64'(r), 64'd2);

    // DIV 100/3 with an ignored restart at cycle 3 and four stalled cycles.
    ia.op = 3'd3; ia.rs = 8'd100; ia.rt = 8'd3; ia.start = 1'b1; ia.enable = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b0;
    c = 1; seen = 1'b0;
    while (!seen && c < 100) begin
      if (ia.done === 1'b1) seen = 1'b1;
      else begin
        chk("stall_result_hold", 64'(ia.result), 64'd2);
        ia.start = (c == 3);
        if (c == 3) begin ia.op = 3'd0; ia.rs = 8'd1; ia.rt = 8'd1; end
        ia.enable = !(c >= 5 && c <= 8);
        @(posedge clk); #1; c++;
      end
    end
    ia.enable = 1'b1;
    chk("stall_done_seen", 64'(seen), 64'd1);
    chk("stall_latency",   64'(c), 64'd13);
    chk("stall_result",    64'(ia.result), 64'd33);
    $display("div_stall rs=64 rt=3 result=%0h cycles=%0d", ia.result, c);
    ia.op = 3'd0; ia.rs = 8'd7; ia.rt = 8'd8; ia.start = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b0;
    chk("b2b_done",   64'(ia.done),   64'd1);
    chk("b2b_result", 64'(ia.result), 64'd15);
    $display("add_b2b rs=7 rt=8 result=%0h", ia.result);
    @(posedge clk); #1;

    // Reset in the middle of DIV 255/1.
    ia.op = 3'd3; ia.rs = 8'd255; ia.rt = 8'd1; ia.start = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midreset_busy_before", 64'(ia.busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_busy",   64'(ia.busy),   64'd0);
    chk("midreset_result", 64'(ia.result), 64'd0);
    chk("midreset_done",   64'(ia.done),   64'd0);
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ia.done === 1'b1) pulses++;
    end
    chk("midreset_no_done", 64'(pulses), 64'd0);
    $display("div_reset rs=ff rt=1 aborted pulses=%0d", pulses);

    run_c(3'd3, 16'd60000, 16'd250, "div16");
    run_c(3'd5, 16'd60000, 16'd257, "mod16");
    for (int i = 0; i < 6; i++)
      run_c(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom_range(0, 300)),
            $sformatf("rnd16_%0d", i));

    for (int i = 0; i < 30; i++) begin
      logic [7:0] rb;
      rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      run_a(3'($urandom_range(0, 7)), 8'($urandom), rb, (i % 2) == 1,
            $sformatf("rnd8_%0d", i), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
